// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - stall, bubble and flush sequencing for the 5-stage MIPS pipeline
//
// Purpose:
//   Covers the hazards that forwarding cannot resolve:
//     - load-use hazards (one-cycle stall with an ID/EX bubble)
//     - the multi-cycle mult/div unit (stall while HI/LO is busy)
//     - taken branches resolved in EX (flush IF/ID and bubble ID/EX)
//   Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
//   Without that macro the counter ports are tied to zero and no counter flops exist.
//
// Parameters:
//   MULDIV_CYCLES  number of cycles the mult/div unit stays busy after issue (2..255)
//   CNT_W          width of the busy down-counter; must satisfy 2**CNT_W > MULDIV_CYCLES
//
// Ports:
//   clk, rst_n            pipeline clock; asynchronous active-low reset
//   regRs_IFID/regRt_IFID source register fields of the instruction in ID
//   useRs_IFID/useRt_IFID the instruction in ID actually reads rs / rt
//   MemRead_IDEX          the instruction in EX is a load
//   regRt_IDEX            destination (rt) of that load
//   muldiv_start_ID       the instruction in ID is mult/multu/div/divu
//   hilo_read_ID          the instruction in ID is mfhi/mflo
//   branch_taken_EX       a branch/jump in EX resolved taken this cycle
//   PCWrite, IFIDWrite    PC and IF/ID load enables
//   IFID_flush            clear IF/ID to a NOP
//   IDEX_bubble           zero the ID/EX control signals
//   muldiv_busy           the mult/div unit is occupied
//   muldiv_done           one-cycle pulse on the last busy cycle
//   lu_stall_cnt          load-use stall cycles (saturating)
//   md_stall_cnt          mult/div stall cycles (saturating)
//   flush_cnt             branch flush cycles (saturating)

module hazard_stall_controller #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  regRs_IFID,
    input  logic [4:0]  regRt_IFID,
    input  logic        useRs_IFID,
    input  logic        useRt_IFID,
    input  logic        MemRead_IDEX,
    input  logic [4:0]  regRt_IDEX,
    input  logic        muldiv_start_ID,
    input  logic        hilo_read_ID,
    input  logic        branch_taken_EX,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFID_flush,
    output logic        IDEX_bubble,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [15:0] lu_stall_cnt,
    output logic [15:0] md_stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    logic luHit;
    logic mdHit;
    logic issue;

    // Register $zero never creates a true dependency, so a load targeting it is ignored.
    assign luHit = MemRead_IDEX && (regRt_IDEX != 5'd0) &&
                   ((useRs_IFID && (regRs_IFID == regRt_IDEX)) ||
                    (useRt_IFID && (regRt_IFID == regRt_IDEX)));

    // While busy, both a HI/LO read and a second mult/div must wait for the unit.
    assign mdHit = (state == MD_BUSY) && (hilo_read_ID || muldiv_start_ID);

    // A mult/div in ID only starts the unit if it really advances this cycle.
    assign issue = (state == RUN) && muldiv_start_ID && !branch_taken_EX && !luHit;

    assign muldiv_busy = (state == MD_BUSY);
    assign muldiv_done = (state == MD_BUSY) && (cnt == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;

        case (state)
            RUN: begin
                if (issue) begin
                    stateNext = MD_BUSY;
                    cntNext   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                // A taken branch does not cancel the in-flight operation.
                // The zero check keeps the counter from ever wrapping.
                if ((cnt == CNT_ONE) || (cnt == '0)) begin
                    stateNext = RUN;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - CNT_ONE;
                end
            end
            default: begin
                stateNext = RUN;
                cntNext   = '0;
            end
        endcase

        // Reset holds the front end frozen with NOPs flowing into the pipe.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (branch_taken_EX) begin
            PCWrite     = 1'b1;
            IFIDWrite   = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (luHit || mdHit) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFID_flush  = 1'b0;
            IDEX_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] luCnt;
    logic [15:0] mdCnt;
    logic [15:0] flCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luCnt <= '0;
            mdCnt <= '0;
            flCnt <= '0;
        end else begin
            if (luHit && !branch_taken_EX && (luCnt != 16'hFFFF)) begin
                luCnt <= luCnt + 16'd1;
            end
            if (mdHit && !luHit && !branch_taken_EX && (mdCnt != 16'hFFFF)) begin
                mdCnt <= mdCnt + 16'd1;
            end
            if (branch_taken_EX && (flCnt != 16'hFFFF)) begin
                flCnt <= flCnt + 16'd1;
            end
        end
    end

    assign lu_stall_cnt = luCnt;
    assign md_stall_cnt = mdCnt;
    assign flush_cnt    = flCnt;
`else
    assign lu_stall_cnt = 16'd0;
    assign md_stall_cnt = 16'd0;
    assign flush_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
//
// Two instances share every input: dut4 (MULDIV_CYCLES=4) and dut12 (MULDIV_CYCLES=12).
// Each driven cycle pushes one expected output vector tagged with the instance to check.
// Vector bit order: {PCWrite, IFIDWrite, IFID_flush, IDEX_bubble, muldiv_busy, muldiv_done}.

module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] regRs_IFID = '0;
    logic [4:0] regRt_IFID = '0;
    logic       useRs_IFID = 1'b0;
    logic       useRt_IFID = 1'b0;
    logic       MemRead_IDEX = 1'b0;
    logic [4:0] regRt_IDEX = '0;
    logic       muldiv_start_ID = 1'b0;
    logic       hilo_read_ID = 1'b0;
    logic       branch_taken_EX = 1'b0;

    logic        pcw4, ifw4, fl4, bub4, busy4, done4;
    logic        pcw12, ifw12, fl12, bub12, busy12, done12;
    logic [15:0] luCnt4, mdCnt4, flCnt4;
    logic [15:0] luCnt12, mdCnt12, flCnt12;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MULDIV_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .regRs_IFID(regRs_IFID), .regRt_IFID(regRt_IFID),
        .useRs_IFID(useRs_IFID), .useRt_IFID(useRt_IFID),
        .MemRead_IDEX(MemRead_IDEX), .regRt_IDEX(regRt_IDEX),
        .muldiv_start_ID(muldiv_start_ID), .hilo_read_ID(hilo_read_ID),
        .branch_taken_EX(branch_taken_EX),
        .PCWrite(pcw4), .IFIDWrite(ifw4), .IFID_flush(fl4), .IDEX_bubble(bub4),
        .muldiv_busy(busy4), .muldiv_done(done4),
        .lu_stall_cnt(luCnt4), .md_stall_cnt(mdCnt4), .flush_cnt(flCnt4)
    );

    hazard_stall_controller #(.MULDIV_CYCLES(12), .CNT_W(8)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .regRs_IFID(regRs_IFID), .regRt_IFID(regRt_IFID),
        .useRs_IFID(useRs_IFID), .useRt_IFID(useRt_IFID),
        .MemRead_IDEX(MemRead_IDEX), .regRt_IDEX(regRt_IDEX),
        .muldiv_start_ID(muldiv_start_ID), .hilo_read_ID(hilo_read_ID),
        .branch_taken_EX(branch_taken_EX),
        .PCWrite(pcw12), .IFIDWrite(ifw12), .IFID_flush(fl12), .IDEX_bubble(bub12),
        .muldiv_busy(busy12), .muldiv_done(done12),
        .lu_stall_cnt(luCnt12), .md_stall_cnt(mdCnt12), .flush_cnt(flCnt12)
    );

    localparam logic [5:0] V_RST   = 6'b001100;
    localparam logic [5:0] V_RUN   = 6'b110000;
    localparam logic [5:0] V_LU    = 6'b000100;
    localparam logic [5:0] V_FLUSH = 6'b111100;
    localparam logic [5:0] V_MDST  = 6'b000110;
    localparam logic [5:0] V_MDEND = 6'b000111;
    localparam logic [5:0] V_BUSY  = 6'b110010;
    localparam logic [5:0] V_BLAST = 6'b110011;
    localparam logic [5:0] V_BFL   = 6'b111110;

    typedef struct packed {
        logic       sel;
        logic [7:0] tag;
        logic [5:0] exp;
    } sb_t;

    sb_t sbQ[$];
    int  checks = 0;
    int  failures = 0;

    // Monitor: one output vector per cycle, compared against the oldest expectation.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            sb_t        e;
            logic [5:0] act;
            e = sbQ.pop_front();
            act = e.sel ? {pcw12, ifw12, fl12, bub12, busy12, done12}
                        : {pcw4, ifw4, fl4, bub4, busy4, done4};
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL sb tag=%0d dut=%0s actual=%b expected=%b",
                         e.tag, e.sel ? "dut12" : "dut4", act, e.exp);
            end
        end
    end

    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic mr, input logic [4:0] rtex,
                       input logic ms, input logic hr, input logic bt,
                       input logic [5:0] exp, input logic sel, input logic [7:0] tag);
        sb_t e;
        @(posedge clk);
        #1;
        regRs_IFID = rs;
        regRt_IFID = rt;
        useRs_IFID = urs;
        useRt_IFID = urt;
        MemRead_IDEX = mr;
        regRt_IDEX = rtex;
        muldiv_start_ID = ms;
        hilo_read_ID = hr;
        branch_taken_EX = bt;
        e.sel = sel;
        e.tag = tag;
        e.exp = exp;
        sbQ.push_back(e);
    endtask

    task automatic idle(input logic [5:0] exp, input logic sel, input logic [7:0] tag);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp, sel, tag);
    endtask

    task automatic hilo(input logic [5:0] exp, input logic sel, input logic [7:0] tag);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, exp, sel, tag);
    endtask

    task automatic mult(input logic [5:0] exp, input logic sel, input logic [7:0] tag);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, exp, sel, tag);
    endtask

    task automatic branch(input logic [5:0] exp, input logic sel, input logic [7:0] tag);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, exp, sel, tag);
    endtask

    task automatic luRs(input logic [5:0] exp, input logic sel, input logic [7:0] tag);
        cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, exp, sel, tag);
    endtask

    task automatic rstCycle(input logic sel, input logic [7:0] tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        regRs_IFID = '0; regRt_IFID = '0; useRs_IFID = 1'b0; useRt_IFID = 1'b0;
        MemRead_IDEX = 1'b0; regRt_IDEX = '0; muldiv_start_ID = 1'b0;
        hilo_read_ID = 1'b0; branch_taken_EX = 1'b0;
        sbQ.push_back('{sel: sel, tag: tag, exp: V_RST});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbQ.push_back('{sel: sel, tag: tag + 8'd1, exp: V_RUN});
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        // Reset state on both instances, then release.
        rstCycle(1'b0, 8'd1);
        rstCycle(1'b1, 8'd3);

        // Load-use on rs: exactly one stall cycle, then the load has moved on.
        luRs(V_LU, 1'b0, 8'd10);
        idle(V_RUN, 1'b0, 8'd11);
        // Load into $zero never stalls.
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, 8'd12);
        // Load-use on rt, and the same registers with useRt cleared.
        cyc(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, V_LU, 1'b0, 8'd13);
        cyc(5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, 8'd14);

        // mult at cycle 0, mfhi from cycle 1: busy/stall cycles 1-4, done on 4.
        mult(V_RUN, 1'b0, 8'd20);
        hilo(V_MDST, 1'b0, 8'd21);
        hilo(V_MDST, 1'b0, 8'd22);
        hilo(V_MDST, 1'b0, 8'd23);
        hilo(V_MDEND, 1'b0, 8'd24);
        hilo(V_RUN, 1'b0, 8'd25);
        idle(V_RUN, 1'b0, 8'd26);

        // Branch beats load-use, and a same-cycle mult is discarded.
        cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, V_FLUSH, 1'b0, 8'd30);
        cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, V_FLUSH, 1'b0, 8'd31);
        idle(V_RUN, 1'b0, 8'd32);
        // A mult held by a load-use stall does not start the unit.
        cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, V_LU, 1'b0, 8'd33);
        idle(V_RUN, 1'b0, 8'd34);

        // Branch during MD_BUSY at counter=3 on dut12.
        rstCycle(1'b1, 8'd40);
        mult(V_RUN, 1'b1, 8'd42);
        for (int i = 0; i < 9; i++) idle(V_BUSY, 1'b1, 8'(43 + i));   // counters 12..4
        branch(V_BFL, 1'b1, 8'd52);                                  // counter 3
        idle(V_BUSY, 1'b1, 8'd53);                                   // counter 2
        idle(V_BLAST, 1'b1, 8'd54);                                  // counter 1
        idle(V_RUN, 1'b1, 8'd55);

        // Asynchronous reset mid-busy at counter=10 on dut12.
        mult(V_RUN, 1'b1, 8'd60);
        idle(V_BUSY, 1'b1, 8'd61);                                   // counter 12
        idle(V_BUSY, 1'b1, 8'd62);                                   // counter 11
        rstCycle(1'b1, 8'd63);                                       // low while counter 10
        idle(V_RUN, 1'b1, 8'd65);

        // Performance counters, dut4: 3 lu stalls, 8 md stall cycles, 2 flushes.
        rstCycle(1'b0, 8'd70);
        for (int i = 0; i < 3; i++) begin
            luRs(V_LU, 1'b0, 8'd72);
            idle(V_RUN, 1'b0, 8'd73);
        end
        for (int k = 0; k < 2; k++) begin
            mult(V_RUN, 1'b0, 8'd74);
            hilo(V_MDST, 1'b0, 8'd75);
            hilo(V_MDST, 1'b0, 8'd75);
            hilo(V_MDST, 1'b0, 8'd75);
            hilo(V_MDEND, 1'b0, 8'd76);
            idle(V_RUN, 1'b0, 8'd77);
        end
        branch(V_FLUSH, 1'b0, 8'd78);
        branch(V_FLUSH, 1'b0, 8'd78);
        idle(V_RUN, 1'b0, 8'd79);
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_stall_cnt", luCnt4, 16'd3);
        chk("md_stall_cnt", mdCnt4, 16'd8);
        chk("flush_cnt", flCnt4, 16'd2);
        @(posedge clk);
        #1;
        branch_taken_EX = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        branch_taken_EX = 1'b0;
        @(negedge clk);
        chk("flush_cnt_sat", flCnt4, 16'hFFFF);
        chk("lu_stall_cnt_hold", luCnt4, 16'd3);
`else
        chk("lu_stall_cnt_off", luCnt4, 16'd0);
        chk("md_stall_cnt_off", mdCnt4, 16'd0);
        chk("flush_cnt_off", flCnt4, 16'd0);
`endif

        // Bounded drain of the scoreboard.
        repeat (4) @(negedge clk);
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain actual=%0d expected=0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
